// File: rtl/vga_scan_timing.sv
// VGA raster timing generator: pixel/line counters gated by a pixel-rate enable,
// with all outputs registered one enabled cycle behind the counter state.
module vga_scan_timing #(
    parameter int H_ACTIVE        = 640,
    parameter int H_FRONT         = 16,
    parameter int H_SYNC          = 96,
    parameter int H_BACK          = 48,
    parameter int V_ACTIVE        = 480,
    parameter int V_FRONT         = 10,
    parameter int V_SYNC          = 2,
    parameter int V_BACK          = 33,
    parameter int SYNC_ACTIVE_LOW = 1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_pix_en,
    output logic [8:0] o_scan_row,
    output logic [9:0] o_scan_column,
    output logic       o_active,
    output logic       o_hsync,
    output logic       o_vsync,
    output logic       o_line_start,
    output logic       o_frame_start,
    output logic [7:0] o_frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS     = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS     = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEGIN  = 10'(H_ACTIVE + H_FRONT);
    localparam logic [9:0] HS_END    = 10'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_BEGIN  = 10'(V_ACTIVE + V_FRONT);
    localparam logic [9:0] VS_END    = 10'(V_ACTIVE + V_FRONT + V_SYNC);

    localparam logic SYNC_ON  = (SYNC_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
    localparam logic SYNC_OFF = ~SYNC_ON;

    logic [9:0] h;
    logic [9:0] v;
    logic [9:0] h_next;
    logic [9:0] v_next;
    logic       h_end;
    logic       v_end;
    logic       h_visible;
    logic       v_visible;
    logic       visible;
    logic       hs_on;
    logic       vs_on;
    logic       first_pixel;

    always_comb begin
        h_end       = (h == H_LAST);
        v_end       = (v == V_LAST);
        h_next      = h_end ? '0 : h + 10'd1;
        v_next      = v;
        if (h_end) begin
            v_next = v_end ? '0 : v + 10'd1;
        end
        h_visible   = (h < H_VIS);
        v_visible   = (v < V_VIS);
        visible     = h_visible && v_visible;
        hs_on       = (h >= HS_BEGIN) && (h < HS_END);
        vs_on       = (v >= VS_BEGIN) && (v < VS_END);
        first_pixel = (h == '0) && (v == '0);
    end

    // Outputs describe the position held before this edge's increment.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            h             <= '0;
            v             <= '0;
            o_scan_row    <= '0;
            o_scan_column <= '0;
            o_active      <= 1'b0;
            o_hsync       <= SYNC_OFF;
            o_vsync       <= SYNC_OFF;
            o_line_start  <= 1'b0;
            o_frame_start <= 1'b0;
            o_frame_count <= '0;
        end else if (i_pix_en) begin
            h             <= h_next;
            v             <= v_next;
            o_active      <= visible;
            o_scan_column <= visible ? h : '0;
            o_scan_row    <= visible ? v[8:0] : '0;
            o_hsync       <= hs_on ? SYNC_ON : SYNC_OFF;
            o_vsync       <= vs_on ? SYNC_ON : SYNC_OFF;
            o_line_start  <= (h == '0) && v_visible;
            o_frame_start <= first_pixel;
            if (first_pixel) begin
                o_frame_count <= o_frame_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_vga_scan_timing.sv
// Scoreboard bench for vga_scan_timing on a reduced 12x7 raster so that
// hundreds of frames, enable gaps and mid-frame reset fit in a short run.
module tb_vga_scan_timing;

    localparam int HA = 8, HF = 1, HSW = 2, HB = 1;
    localparam int VA = 4, VF = 1, VSW = 1, VB = 1;
    localparam int HT = HA + HF + HSW + HB;   // 12
    localparam int VT = VA + VF + VSW + VB;   // 7
    localparam int FRAME = HT * VT;           // 84

    typedef struct packed {
        logic       act;
        logic [8:0] row;
        logic [9:0] col;
        logic       hs;
        logic       vs;
        logic       ls;
        logic       fs;
        logic [7:0] fc;
    } out_t;

    localparam out_t RESET_OUT = '{act: 1'b0, row: 9'd0, col: 10'd0, hs: 1'b1,
                                   vs: 1'b1, ls: 1'b0, fs: 1'b0, fc: 8'd0};

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_pix_en = 1'b0;
    logic [8:0] o_scan_row;
    logic [9:0] o_scan_column;
    logic       o_active, o_hsync, o_vsync, o_line_start, o_frame_start;
    logic [7:0] o_frame_count;

    vga_scan_timing #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
        .SYNC_ACTIVE_LOW(1)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_pix_en(i_pix_en),
        .o_scan_row(o_scan_row), .o_scan_column(o_scan_column),
        .o_active(o_active), .o_hsync(o_hsync), .o_vsync(o_vsync),
        .o_line_start(o_line_start), .o_frame_start(o_frame_start),
        .o_frame_count(o_frame_count)
    );

    always #5 i_clk = ~i_clk;

    int   vectors = 0;
    int   miscompares = 0;
    out_t exp_q[$];
    int   mh = 0, mv = 0;
    int   mfc = 0;
    bit   stim_done = 0;
    bit   wrap_seen = 0;

    function automatic out_t dut_out();
        out_t o;
        o.act = o_active;
        o.row = o_scan_row;
        o.col = o_scan_column;
        o.hs  = o_hsync;
        o.vs  = o_vsync;
        o.ls  = o_line_start;
        o.fs  = o_frame_start;
        o.fc  = o_frame_count;
        return o;
    endfunction

    task automatic check_out(input string name, input out_t got, input out_t exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got act=%0b row=%0d col=%0d hs=%0b vs=%0b ls=%0b fs=%0b fc=%0d, expected act=%0b row=%0d col=%0d hs=%0b vs=%0b ls=%0b fs=%0b fc=%0d (t=%0t)",
                     name, got.act, got.row, got.col, got.hs, got.vs, got.ls, got.fs, got.fc,
                     exp.act, exp.row, exp.col, exp.hs, exp.vs, exp.ls, exp.fs, exp.fc, $time);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference position model: expected outputs for the position before increment.
    function automatic out_t model_out();
        out_t e;
        e.act = (mh < HA) && (mv < VA);
        e.row = e.act ? 9'(mv) : 9'd0;
        e.col = e.act ? 10'(mh) : 10'd0;
        e.hs  = !((mh >= HA + HF) && (mh < HA + HF + HSW));
        e.vs  = !((mv >= VA + VF) && (mv < VA + VF + VSW));
        e.ls  = (mh == 0) && (mv < VA);
        e.fs  = (mh == 0) && (mv == 0);
        e.fc  = 8'((mfc + (e.fs ? 1 : 0)) % 256);
        return e;
    endfunction

    task automatic apply(input logic en);
        out_t e;
        @(negedge i_clk);
        i_pix_en = en;
        if (en) begin
            e = model_out();
            if (e.fs) mfc = (mfc + 1) % 256;
            exp_q.push_back(e);
            mh = mh + 1;
            if (mh == HT) begin
                mh = 0;
                mv = (mv + 1) % VT;
            end
        end
    endtask

    // Monitor: pops and compares on enabled edges, checks hold on idle edges,
    // and measures pulse spacing / sync widths from the DUT outputs.
    initial begin : monitor
        out_t got, exp, prev;
        logic en_s, rst_s;
        int en_cnt, lines, vs_low, max_row, lgap, hrun, prev_fc;
        bit fs_seen, ls_seen;
        prev = RESET_OUT;
        en_cnt = 0; lines = 0; vs_low = 0; max_row = 0; lgap = 0; hrun = 0;
        prev_fc = 0; fs_seen = 0; ls_seen = 0;
        forever begin
            @(posedge i_clk);
            en_s  = i_pix_en;
            rst_s = i_rst_n;
            #1;
            got = dut_out();
            if (!rst_s || !i_rst_n) begin
                en_cnt = 0; lines = 0; vs_low = 0; max_row = 0; lgap = 0; hrun = 0;
                prev_fc = 0; fs_seen = 0; ls_seen = 0;
            end else if (en_s) begin
                if (exp_q.size() == 0) begin
                    check_int("scoreboard_underflow", 1, 0);
                end else begin
                    exp = exp_q.pop_front();
                    check_out("enabled_output", got, exp);
                end
                en_cnt++;
                lgap++;
                if (got.fs) begin
                    if (fs_seen) begin
                        check_int("frame_period", en_cnt, FRAME);
                        check_int("line_starts_per_frame", lines, VA);
                        check_int("vsync_low_enables", vs_low, VSW * HT);
                        check_int("max_row", max_row, VA - 1);
                    end
                    fs_seen = 1;
                    en_cnt = 0; lines = 0; vs_low = 0; max_row = 0;
                    if (got.fc == 8'd0 && prev_fc == 255) wrap_seen = 1;
                end
                if (got.ls) begin
                    if (ls_seen && !got.fs) check_int("line_period", lgap, HT);
                    lines++;
                    lgap = 0;
                    ls_seen = 1;
                end
                if (!got.vs) vs_low++;
                if (got.act && int'(got.row) > max_row) max_row = int'(got.row);
                if (!got.hs) begin
                    hrun++;
                end else if (hrun != 0) begin
                    check_int("hsync_width", hrun, HSW);
                    hrun = 0;
                end
                prev_fc = int'(got.fc);
            end else begin
                check_out("hold_when_disabled", got, prev);
            end
            prev = got;
        end
    end

    initial begin : stimulus
        int n;
        // Reset state while held.
        #12;
        check_out("reset_state", dut_out(), RESET_OUT);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // Continuous enable for three frames.
        for (int i = 0; i < 3 * FRAME; i++) apply(1'b1);

        // Enable pattern 1,0,0,1 then pseudo-random gaps over two frames of enabled cycles.
        apply(1'b1); apply(1'b0); apply(1'b0); apply(1'b1);
        n = 0;
        while (n < 2 * FRAME) begin
            logic en;
            en = 1'($urandom_range(0, 1));
            apply(en);
            if (en) n++;
        end

        // Run to position h=5, v=2 and drop reset between clock edges.
        while (!(mh == 5 && mv == 2)) apply(1'b1);
        apply(1'b1);
        @(posedge i_clk);
        #3;
        i_rst_n = 1'b0;
        #1;
        check_out("async_reset_mid_frame", dut_out(), RESET_OUT);
        i_pix_en = 1'b0;
        check_int("queue_empty_at_reset", exp_q.size(), 0);
        mh = 0; mv = 0; mfc = 0;
        repeat (3) @(negedge i_clk);
        check_out("reset_held", dut_out(), RESET_OUT);
        i_rst_n = 1'b1;

        // 256+ frames to see the frame counter wrap 255 -> 0.
        for (int i = 0; i < 256 * FRAME + 10; i++) apply(1'b1);
        apply(1'b0);
        repeat (3) @(negedge i_clk);
        stim_done = 1;
    end

    initial begin : finisher
        int budget;
        budget = 0;
        while (!stim_done && budget < 60000) begin
            @(negedge i_clk);
            budget++;
        end
        check_int("stimulus_completed", int'(stim_done), 1);
        check_int("queue_drained", exp_q.size(), 0);
        check_int("frame_count_wrapped", int'(wrap_seen), 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vga_scan_timing.md
VGA_SCAN_TIMING -- requirements
Module: vga_scan_timing

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FRONT/H_SYNC/H_BACK, defaults 16/96/48, horizontal porch and sync widths in pixels.
REQ-003 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 SHALL have parameters V_FRONT/V_SYNC/V_BACK, defaults 10/2/33, vertical porch and sync widths in lines.
REQ-005 SHALL have parameter SYNC_ACTIVE_LOW, default 1; 1 means the sync outputs are low while asserted.
REQ-006 SHALL have port i_clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-007 SHALL have port i_rst_n, input, 1 bit, reset, asynchronous and active-low.
REQ-008 SHALL have port i_pix_en, input, 1 bit, pixel-rate enable; state advances only on cycles where it is high.
REQ-009 SHALL have port o_scan_row, output, 9 bits, visible line index 0..479; it feeds the text area row input.
REQ-010 SHALL have port o_scan_column, output, 10 bits, visible pixel index 0..639; it feeds the text area column input.
REQ-011 SHALL have port o_active, output, 1 bit, high when the current pixel is visible.
REQ-012 SHALL have ports o_hsync and o_vsync, output, 1 bit each, sync signals with polarity set by SYNC_ACTIVE_LOW.
REQ-013 SHALL have ports o_line_start and o_frame_start, output, 1 bit each, one-enable pulses.
REQ-014 SHALL have port o_frame_count, output, 8 bits, free-running frame counter.

Function
REQ-015 SHALL keep internal counters h (10 bits) and v (10 bits): H_TOTAL=sum of the H parameters (800), V_TOTAL=sum of the V parameters (525).
REQ-016 SHALL do the following on each enabled cycle: h increments; at H_TOTAL-1, h wraps to 0 and v increments; at V_TOTAL-1 with h=H_TOTAL-1, v wraps to 0.
REQ-017 SHALL register every output from the pre-increment (h,v) on the same enabled edge, giving latency of exactly one enabled cycle from counter state to outputs.
REQ-018 SHALL hold all outputs and counters unchanged on cycles with i_pix_en low; pulses remain at their last value until the next enabled edge.
REQ-019 SHALL drive o_active=1 if and only if h<H_ACTIVE and v<V_ACTIVE.
REQ-020 SHALL drive o_scan_column=h[9:0] and o_scan_row=v[8:0] while active; both read 0 while not active.
REQ-021 SHALL assert hsync for H_ACTIVE+H_FRONT <= h < H_ACTIVE+H_FRONT+H_SYNC (656..751).
REQ-022 SHALL assert vsync for V_ACTIVE+V_FRONT <= v < V_ACTIVE+V_FRONT+V_SYNC (490..491), on whole lines.
REQ-023 SHALL drive o_line_start=1 for h=0 with v<V_ACTIVE, and 0 otherwise.
REQ-024 SHALL drive o_frame_start=1 for h=0 and v=0, and 0 otherwise.
REQ-025 SHALL increment o_frame_count on the enabled edge that registers o_frame_start=1, and SHALL wrap it from 255 to 0.
REQ-026 SHALL produce exactly H_TOTAL×V_TOTAL (420000) enabled cycles per frame, with no skipped or duplicated positions.

Reset
REQ-027 SHALL, while i_rst_n is low, immediately force h=0, v=0, o_scan_row=0, o_scan_column=0, o_active=0, o_line_start=0, o_frame_start=0 and o_frame_count=0, and drive syncs to their deasserted level.
REQ-028 SHALL, on the first enabled edge after reset release, register position (0,0): o_active=1, o_line_start=1, o_frame_start=1, o_frame_count=1.
REQ-029 SHALL, on reset assertion mid-line or mid-frame, abandon the current position with no completion of the line or frame.

Verification
REQ-030 SHALL cover: i_pix_en held 1 after reset; count enables between o_frame_start pulses -> 420000; between o_line_start pulses in a frame -> 800; 480 line_start pulses per frame.
REQ-031 SHALL cover: observe one line -> o_hsync low (SYNC_ACTIVE_LOW=1) for exactly 96 enables, starting when registered h=656; o_active high for columns 0..639 only.
REQ-032 SHALL cover: observe one frame -> o_vsync low for exactly 1600 enables (lines 490-491); o_scan_row reaches 479 and never exceeds it; row/col read 0 during blanking.
REQ-033 SHALL cover: i_pix_en toggled 1,0,0,1 pseudo-randomly -> outputs change only on enabled edges; the sequence of enabled outputs is identical to the always-enabled run.
REQ-034 SHALL cover: assert i_rst_n low at h=300, v=200 without a clock edge -> outputs reach reset values asynchronously; after release, the first enabled edge yields (0,0) with o_frame_start=1.
REQ-035 SHALL cover: run 256 frames -> o_frame_count goes 255 to 0 on the 256th frame_start, with no glitch on other outputs.
